// File: rtl/spi_master_ctrl_if.sv
// ---------------------------------------------------------------------------
// spi_master_ctrl_if
//
// Groups the host-side request/response signals and the SPI pad signals of
// the spi_master_ctrl block.
//
//   i_start    host -> ctrl  transfer request
//   i_tx_data  host -> ctrl  word to send (MSB first)
//   i_cpol     host -> ctrl  SCLK idle level
//   i_cpha     host -> ctrl  0: sample leading edge, 1: sample trailing edge
//   i_div      host -> ctrl  SCLK half-period select (H = i_div+1 clk cycles)
//   i_miso     pad  -> ctrl  serial data from slave
//   o_sclk     ctrl -> pad   SPI clock
//   o_cs_n     ctrl -> pad   active-low chip select
//   o_mosi     ctrl -> pad   serial data to slave
//   o_busy     ctrl -> host  transfer in progress
//   o_done     ctrl -> host  one-cycle completion pulse
//   o_rx_data  ctrl -> host  last received word
//
// Modport "master" is the controller's view; modport "slave" is the view of
// whatever drives the controller (host register file plus pad model).
// ---------------------------------------------------------------------------
interface spi_master_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 4
);
    logic                  i_start;
    logic [DATA_WIDTH-1:0] i_tx_data;
    logic                  i_cpol;
    logic                  i_cpha;
    logic [DIV_WIDTH-1:0]  i_div;
    logic                  i_miso;
    logic                  o_sclk;
    logic                  o_cs_n;
    logic                  o_mosi;
    logic                  o_busy;
    logic                  o_done;
    logic [DATA_WIDTH-1:0] o_rx_data;

    modport master (
        input  i_start,
        input  i_tx_data,
        input  i_cpol,
        input  i_cpha,
        input  i_div,
        input  i_miso,
        output o_sclk,
        output o_cs_n,
        output o_mosi,
        output o_busy,
        output o_done,
        output o_rx_data
    );

    modport slave (
        output i_start,
        output i_tx_data,
        output i_cpol,
        output i_cpha,
        output i_div,
        output i_miso,
        input  o_sclk,
        input  o_cs_n,
        input  o_mosi,
        input  o_busy,
        input  o_done,
        input  o_rx_data
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// ---------------------------------------------------------------------------
// spi_master_ctrl
//
// Sequences a single SPI master transfer. A start request in IDLE latches the
// transmit word and the CPOL/CPHA/divider settings, drops CS_N, then walks
// through SETUP (one idle half-period), XFER (2*DATA_WIDTH SCLK toggles),
// HOLD (one idle half-period with CS_N still low) and a one-cycle DONE that
// raises CS_N and presents the received word with a done pulse.
//
// Ports:
//   clk   system clock, all logic on the rising edge
//   rst   asynchronous, active-high reset
//   bus   spi_master_ctrl_if.master (host request/response + SPI pads)
//
// Every output is driven straight from a flop, so the pads never see
// combinational glitches. i_miso is used raw; synchronising it is left to
// the integrator.
// ---------------------------------------------------------------------------
module spi_master_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 4
) (
    input logic                clk,
    input logic                rst,
    spi_master_ctrl_if.master  bus
);

    localparam int EDGE_W    = $clog2(2 * DATA_WIDTH);
    localparam int LAST_EDGE = 2 * DATA_WIDTH - 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        DONE
    } state_t;

    state_t                state_q,    state_d;
    logic [DATA_WIDTH-1:0] tx_q,       tx_d;
    logic [DATA_WIDTH-1:0] rx_q,       rx_d;
    logic                  cpol_q,     cpol_d;
    logic                  cpha_q,     cpha_d;
    logic [DIV_WIDTH-1:0]  div_q,      div_d;
    logic [DIV_WIDTH-1:0]  hp_cnt_q,   hp_cnt_d;
    logic [EDGE_W-1:0]     edge_cnt_q, edge_cnt_d;
    logic                  sclk_q,     sclk_d;
    logic                  cs_n_q,     cs_n_d;
    logic                  mosi_q,     mosi_d;
    logic                  busy_q,     busy_d;
    logic                  done_q,     done_d;
    logic [DATA_WIDTH-1:0] rx_data_q,  rx_data_d;

    logic tick;
    logic lead_edge;
    logic first_edge;
    logic last_edge;
    logic do_sample;
    logic do_shift;

    // Next-state and next-output logic.
    // hp_cnt counts 0..div, so "tick" marks the end of each half-period of H
    // clk cycles. The first tick leaves SETUP and is already SCLK toggle 1;
    // edge_cnt holds (toggle number - 1), so an even edge_cnt is a leading
    // edge and an odd one a trailing edge.
    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        div_d      = div_q;
        hp_cnt_d   = hp_cnt_q;
        edge_cnt_d = edge_cnt_q;
        sclk_d     = sclk_q;
        cs_n_d     = cs_n_q;
        mosi_d     = mosi_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        rx_data_d  = rx_data_q;

        tick       = (hp_cnt_q == div_q);
        lead_edge  = ~edge_cnt_q[0];
        first_edge = (edge_cnt_q == '0);
        last_edge  = (edge_cnt_q == EDGE_W'(LAST_EDGE));
        do_sample  = 1'b0;
        do_shift   = 1'b0;

        case (state_q)
            IDLE: begin
                // SCLK tracks the requested idle level while nothing is going on.
                sclk_d     = bus.i_cpol;
                mosi_d     = 1'b0;
                cs_n_d     = 1'b1;
                busy_d     = 1'b0;
                hp_cnt_d   = '0;
                edge_cnt_d = '0;
                if (bus.i_start) begin
                    tx_d    = bus.i_tx_data;
                    cpol_d  = bus.i_cpol;
                    cpha_d  = bus.i_cpha;
                    div_d   = bus.i_div;
                    busy_d  = 1'b1;
                    cs_n_d  = 1'b0;
                    mosi_d  = bus.i_tx_data[DATA_WIDTH-1];
                    state_d = SETUP;
                end
            end

            SETUP, XFER: begin
                if (tick) begin
                    hp_cnt_d = '0;
                    sclk_d   = ~sclk_q;
                    state_d  = XFER;

                    // CPHA=0: data is captured on leading edges and the next
                    // bit is presented on trailing edges (except after the
                    // final bit). CPHA=1: the next bit is presented on leading
                    // edges (the first leading edge keeps the MSB already on
                    // the line) and captured on trailing edges.
                    if (!cpha_q) begin
                        do_sample = lead_edge;
                        do_shift  = ~lead_edge & ~last_edge;
                    end else begin
                        do_sample = ~lead_edge;
                        do_shift  = lead_edge & ~first_edge;
                    end

                    if (last_edge) begin
                        edge_cnt_d = '0;
                        state_d    = HOLD;
                    end else begin
                        edge_cnt_d = edge_cnt_q + 1'b1;
                    end
                end else begin
                    hp_cnt_d = hp_cnt_q + 1'b1;
                end

                if (do_sample) begin
                    rx_d = (rx_q << 1) | DATA_WIDTH'(bus.i_miso);
                end
                if (do_shift) begin
                    tx_d = tx_q << 1;
                end
                mosi_d = tx_d[DATA_WIDTH-1];
            end

            HOLD: begin
                // The last toggle has already returned SCLK to its idle level.
                sclk_d = cpol_q;
                if (tick) begin
                    hp_cnt_d  = '0;
                    cs_n_d    = 1'b1;
                    mosi_d    = 1'b0;
                    done_d    = 1'b1;
                    rx_data_d = rx_q;
                    state_d   = DONE;
                end else begin
                    hp_cnt_d = hp_cnt_q + 1'b1;
                end
            end

            DONE: begin
                // i_start is deliberately not looked at here: a request made
                // during DONE is dropped, not queued.
                sclk_d  = cpol_q;
                mosi_d  = 1'b0;
                cs_n_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers. Reset aborts any transfer on the spot,
    // including clearing the received word, and never produces a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tx_q       <= '0;
            rx_q       <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            div_q      <= '0;
            hp_cnt_q   <= '0;
            edge_cnt_q <= '0;
            sclk_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            div_q      <= div_d;
            hp_cnt_q   <= hp_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            sclk_q     <= sclk_d;
            cs_n_q     <= cs_n_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rx_data_q  <= rx_data_d;
        end
    end

    assign bus.o_sclk    = sclk_q;
    assign bus.o_cs_n    = cs_n_q;
    assign bus.o_mosi    = mosi_q;
    assign bus.o_busy    = busy_q;
    assign bus.o_done    = done_q;
    assign bus.o_rx_data = rx_data_q;

endmodule
